// File: rtl/sdpram_if.sv
// Signal bundle for the simple dual-port RAM: write port A and read port B.
// The master drives addresses, strobes and write data, and the RAM returns the registered read data.
interface sdpram_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = 1
);

  logic [ADDR_WIDTH-1:0] addra;
  logic [STRB_WIDTH-1:0] wena;
  logic [DATA_WIDTH-1:0] dina;
  logic [ADDR_WIDTH-1:0] addrb;
  logic                  renb;
  logic [DATA_WIDTH-1:0] doutb;
  logic                  dvalb;

  modport sdp_m (
    output addra, wena, dina, addrb, renb,
    input  doutb, dvalb
  );

  modport sdp_s (
    input  addra, wena, dina, addrb, renb,
    output doutb, dvalb
  );

endinterface

// File: rtl/simple_dual_port_ram.sv
// Simple dual-port RAM: port A is write-only and port B is read-only, with a 1-cycle registered read.
// Port B is read-first. Out-of-range addresses are dropped on write and read back as zero.
module simple_dual_port_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter bit BYTE_WRITE = 1'b0,
  parameter int ADDR_WIDTH = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1,
  parameter int STRB_WIDTH = BYTE_WRITE ? DATA_WIDTH / 8 : 1
) (
  input  logic    clk,
  input  logic    rst,
  sdpram_if.sdp_s ifp
);

  if (BYTE_WRITE && (DATA_WIDTH % 8 != 0)) begin : g_width_check
    $error("simple_dual_port_ram: BYTE_WRITE=1 requires DATA_WIDTH to be a multiple of 8");
  end

  // NOTE: the array has no reset and no initial contents. Clearing it would prevent
  // block-RAM inference, and reset leaves the stored words untouched.
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] doutb_q;
  logic                  dvalb_q;

  // With a power-of-two depth, every address that fits the port is valid.
  if (MEM_DEPTH == (1 << ADDR_WIDTH)) begin : g_full_range
    assign wr_in_range = 1'b1;
    assign rd_in_range = 1'b1;
  end else begin : g_partial_range
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(MEM_DEPTH);
    assign wr_in_range = ({1'b0, ifp.addra} < DEPTH_W);
    assign rd_in_range = ({1'b0, ifp.addrb} < DEPTH_W);
  end

  if (BYTE_WRITE) begin : g_byte_write
    always_ff @(posedge clk) begin
      if (!rst && wr_in_range) begin
        for (int i = 0; i < STRB_WIDTH; i++) begin
          if (ifp.wena[i]) begin
            mem[ifp.addra][8*i +: 8] <= ifp.dina[8*i +: 8];
          end
        end
      end
    end
  end else begin : g_word_write
    always_ff @(posedge clk) begin
      if (!rst && wr_in_range && ifp.wena[0]) begin
        mem[ifp.addra] <= ifp.dina;
      end
    end
  end

  // NOTE: the write and read processes both use non-blocking assignments. As a result,
  // a read of an address being written samples the old word, which gives read-first
  // behaviour without any bypass logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      doutb_q <= '0;
      dvalb_q <= 1'b0;
    end else if (ifp.renb) begin
      dvalb_q <= 1'b1;
      if (rd_in_range) begin
        doutb_q <= mem[ifp.addrb];
      end else begin
        doutb_q <= '0;
      end
    end else begin
      dvalb_q <= 1'b0;
    end
  end

  assign ifp.doutb = doutb_q;
  assign ifp.dvalb = dvalb_q;

endmodule

// File: tb/tb_simple_dual_port_ram.sv
// Directed bench for simple_dual_port_ram: a word-write 1024-deep instance and a byte-write
// 1000-deep instance. The second instance exercises byte strobes and out-of-range addresses.
module tb_simple_dual_port_ram;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  sdpram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .STRB_WIDTH(1)) if0 ();
  sdpram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .STRB_WIDTH(4)) if1 ();

  simple_dual_port_ram #(.DATA_WIDTH(32), .MEM_DEPTH(1024), .BYTE_WRITE(1'b0)) u_word (
    .clk (clk),
    .rst (rst),
    .ifp (if0)
  );

  simple_dual_port_ram #(.DATA_WIDTH(32), .MEM_DEPTH(1000), .BYTE_WRITE(1'b1)) u_byte (
    .clk (clk),
    .rst (rst),
    .ifp (if1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    if0.addra = '0; if0.wena = '0; if0.dina = '0;
    if0.addrb = '0; if0.renb = 1'b0;
    if1.addra = '0; if1.wena = '0; if1.dina = '0;
    if1.addrb = '0; if1.renb = 1'b0;

    // Power-up reset held for two cycles.
    rst = 1'b1;
    step(); step();
    check("reset_doutb", if0.doutb, 32'h0);
    check("reset_dvalb", 32'(if0.dvalb), 32'h0);
    rst = 1'b0;

    // Store a known word, then try to overwrite it while reset is asserted.
    if0.wena = 1'b1; if0.addra = 10'h002; if0.dina = 32'h0BAD_F00D;
    step();
    rst = 1'b1;
    if0.dina = 32'hFFFF_FFFF; if0.renb = 1'b1; if0.addrb = 10'h002;
    step(); step();
    check("rst_wr_doutb", if0.doutb, 32'h0);
    check("rst_wr_dvalb", 32'(if0.dvalb), 32'h0);
    rst = 1'b0; if0.wena = 1'b0;
    step();
    check("rst_wr_kept", if0.doutb, 32'h0BAD_F00D);
    check("rst_wr_kept_v", 32'(if0.dvalb), 32'h1);
    if0.renb = 1'b0;

    // Write and then read back with a latency of one cycle.
    if0.wena = 1'b1; if0.addra = 10'h001; if0.dina = 32'h0000_0055;
    step();
    if0.wena = 1'b0; if0.renb = 1'b1; if0.addrb = 10'h001;
    step();
    check("rd1_doutb", if0.doutb, 32'h0000_0055);
    check("rd1_dvalb", 32'(if0.dvalb), 32'h1);
    if0.renb = 1'b0;
    step();
    check("rd1_idle_dvalb", 32'(if0.dvalb), 32'h0);
    check("rd1_idle_hold", if0.doutb, 32'h0000_0055);

    // Same-address read and write: the read returns the old contents.
    if0.wena = 1'b1; if0.addra = 10'h005; if0.dina = 32'h1111_1111;
    step();
    if0.dina = 32'h0000_0055; if0.addrb = 10'h005; if0.renb = 1'b1;
    step();
    check("rf_first_old", if0.doutb, 32'h1111_1111);
    step();
    check("rf_second_new", if0.doutb, 32'h0000_0055);
    step();
    check("rf_third_new", if0.doutb, 32'h0000_0055);
    check("rf_third_v", 32'(if0.dvalb), 32'h1);
    if0.wena = 1'b0; if0.renb = 1'b0;

    // Top and bottom addresses, read back to back.
    if0.wena = 1'b1; if0.addra = 10'h3FF; if0.dina = 32'hAAAA_5555;
    step();
    if0.addra = 10'h000; if0.dina = 32'h1234_5678;
    step();
    if0.wena = 1'b0; if0.renb = 1'b1; if0.addrb = 10'h3FF;
    step();
    check("b2b_top", if0.doutb, 32'hAAAA_5555);
    check("b2b_top_v", 32'(if0.dvalb), 32'h1);
    if0.addrb = 10'h000;
    step();
    check("b2b_bot", if0.doutb, 32'h1234_5678);
    check("b2b_bot_v", 32'(if0.dvalb), 32'h1);
    if0.renb = 1'b0;
    step();
    check("b2b_idle_v", 32'(if0.dvalb), 32'h0);
    check("b2b_idle_hold", if0.doutb, 32'h1234_5678);

    // Read and write at different addresses in the same cycle.
    if0.wena = 1'b1; if0.addra = 10'h007; if0.dina = 32'h0000_0077;
    if0.renb = 1'b1; if0.addrb = 10'h3FF;
    step();
    check("indep_rd", if0.doutb, 32'hAAAA_5555);
    if0.wena = 1'b0; if0.addrb = 10'h007;
    step();
    check("indep_wr", if0.doutb, 32'h0000_0077);

    // Assert reset in the middle of a read stream.
    if0.addrb = 10'h001;
    step();
    check("mid_pre", if0.doutb, 32'h0000_0055);
    rst = 1'b1;
    step();
    check("mid_rst_doutb", if0.doutb, 32'h0);
    check("mid_rst_dvalb", 32'(if0.dvalb), 32'h0);
    rst = 1'b0;
    step();
    check("mid_resume", if0.doutb, 32'h0000_0055);
    check("mid_resume_v", 32'(if0.dvalb), 32'h1);
    if0.renb = 1'b0;

    // Byte strobes on the byte-write instance.
    if1.wena = 4'b1111; if1.addra = 10'h010; if1.dina = 32'hFFFF_FFFF;
    step();
    if1.wena = 4'b0101; if1.dina = 32'h1122_3344;
    step();
    if1.wena = 4'b0000; if1.renb = 1'b1; if1.addrb = 10'h010;
    step();
    check("byte_merge", if1.doutb, 32'hFF22_FF44);
    check("byte_merge_v", 32'(if1.dvalb), 32'h1);

    // Last valid address, and an out-of-range address at depth 1000.
    if1.renb = 1'b0;
    if1.wena = 4'b1111; if1.addra = 10'h3E7; if1.dina = 32'hCAFE_F00D;
    step();
    if1.addra = 10'h3F0; if1.dina = 32'hDEAD_BEEF;
    step();
    if1.wena = 4'b0000; if1.renb = 1'b1; if1.addrb = 10'h3E7;
    step();
    check("last_valid", if1.doutb, 32'hCAFE_F00D);
    if1.addrb = 10'h3F0;
    step();
    check("oor_zero", if1.doutb, 32'h0);
    check("oor_dvalb", 32'(if1.dvalb), 32'h1);
    if1.addrb = 10'h3E7;
    step();
    check("oor_no_alias", if1.doutb, 32'hCAFE_F00D);
    if1.renb = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
